// File: rtl/light_phase_sequencer_pkg.sv
// Shared phase encoding, timer width and phase-order helper for the light sequencer.
package light_pkg;
  localparam int TIMER_W   = 6;
  localparam int TIMER_MAX = (1 << TIMER_W) - 1;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2,
    MAINT  = 2'd3
  } phase_e;

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      GREEN:   next_phase = YELLOW;
      YELLOW:  next_phase = RED;
      default: next_phase = GREEN;
    endcase
  endfunction
endpackage

// File: rtl/light_phase_sequencer_if.sv
// Request inputs and lamp/timer outputs of the light sequencer; master drives requests, slave drives lamps.
interface light_phase_sequencer_if;
  import light_pkg::*;

  logic               enable;
  logic               ped_req;
  logic               maint_req;
  logic               green;
  logic               yellow;
  logic               red;
  logic [TIMER_W-1:0] timer;
  logic [1:0]         phase;
  logic               phase_done;
  logic               ped_ack;

  modport master (
    output enable, ped_req, maint_req,
    input  green, yellow, red, timer, phase, phase_done, ped_ack
  );

  modport slave (
    input  enable, ped_req, maint_req,
    output green, yellow, red, timer, phase, phase_done, ped_ack
  );
endinterface

// File: rtl/light_phase_sequencer_phase_timer.sv
// Phase timer: registered count with hold > clear > load-1 > increment priority; at_limit is combinational.
module phase_timer
  import light_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               hold,
  input  logic               clear,
  input  logic               load_one,
  input  logic [TIMER_W-1:0] limit,
  output logic [TIMER_W-1:0] count,
  output logic               at_limit
);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (!hold) begin
      if (clear)
        count <= '0;
      else if (load_one)
        count <= TIMER_W'(1);
      else
        count <= count + 1'b1;
    end
  end

  assign at_limit = (count == limit);

endmodule

// File: rtl/light_phase_sequencer.sv
// GREEN->YELLOW->RED sequencer with pedestrian early exit and maintenance override; all outputs registered, 1-cycle.
// enable=0 freezes everything except ped_req capture; LIGHT_SEQ_FLASH_YELLOW_EN flashes yellow in MAINT.
module light_phase_sequencer
  import light_pkg::*;
#(
  parameter int GREEN_LEN  = 35,
  parameter int YELLOW_LEN = 5,
  parameter int RED_LEN    = 20,
  parameter int MIN_GREEN  = 10,
  parameter int FLASH_HALF = 2
)(
  input logic                    clock,
  input logic                    reset_n,
  light_phase_sequencer_if.slave bus
);

  if (GREEN_LEN < 1 || GREEN_LEN > TIMER_MAX ||
      YELLOW_LEN < 1 || YELLOW_LEN > TIMER_MAX ||
      RED_LEN < 1 || RED_LEN > TIMER_MAX ||
      MIN_GREEN < 1 || MIN_GREEN > GREEN_LEN ||
      FLASH_HALF < 1) begin : g_bad_cfg
    $fatal(1, "light_phase_sequencer: illegal phase length parameter");
  end

  phase_e             phase_q, phase_n;
  logic               ped_pending_q, ped_pending_n;
  logic               phase_done_q, phase_done_n;
  logic               ped_ack_q, ped_ack_n;
  logic               green_q, green_n;
  logic               yellow_q, yellow_n;
  logic               red_q, red_n;
  logic               tmr_clear, tmr_load_one, tmr_at_limit, early_exit;
  logic [TIMER_W-1:0] tmr_limit, tmr_count;

`ifdef LIGHT_SEQ_FLASH_YELLOW_EN
  localparam int FW = 16;
  logic [FW-1:0] flash_cnt_q, flash_cnt_n;
  logic          flash_on_q, flash_on_n;
`endif

  phase_timer u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .hold     (!bus.enable),
    .clear    (tmr_clear),
    .load_one (tmr_load_one),
    .limit    (tmr_limit),
    .count    (tmr_count),
    .at_limit (tmr_at_limit)
  );

  always_comb begin
    case (phase_q)
      GREEN:   tmr_limit = TIMER_W'(GREEN_LEN);
      YELLOW:  tmr_limit = TIMER_W'(YELLOW_LEN);
      default: tmr_limit = TIMER_W'(RED_LEN);
    endcase
  end

  assign early_exit = (phase_q == GREEN) && ped_pending_q && (tmr_count >= TIMER_W'(MIN_GREEN));

  always_comb begin
    phase_n       = phase_q;
    ped_pending_n = ped_pending_q | bus.ped_req;
    phase_done_n  = 1'b0;
    ped_ack_n     = 1'b0;
    tmr_clear     = 1'b0;
    tmr_load_one  = 1'b0;

    if (bus.enable) begin
      if (phase_q == MAINT) begin
        if (!bus.maint_req) begin
          phase_n      = RED;
          tmr_load_one = 1'b1;
          phase_done_n = 1'b1;
        end else begin
          tmr_clear = 1'b1;
        end
      end else if (tmr_at_limit || early_exit) begin
        phase_done_n = 1'b1;
        // Maintenance wins the boundary; a pending pedestrian request survives it.
        if (bus.maint_req) begin
          phase_n   = MAINT;
          tmr_clear = 1'b1;
        end else begin
          phase_n      = next_phase(phase_q);
          tmr_load_one = 1'b1;
          if (early_exit) begin
            ped_pending_n = bus.ped_req;
            ped_ack_n     = 1'b1;
          end
        end
      end
    end

    green_n  = (phase_n == GREEN);
    yellow_n = (phase_n == YELLOW);
    red_n    = (phase_n == RED) || (phase_n == MAINT);

`ifdef LIGHT_SEQ_FLASH_YELLOW_EN
    flash_cnt_n = flash_cnt_q;
    flash_on_n  = flash_on_q;
    if (bus.enable && phase_n == MAINT) begin
      if (phase_q != MAINT) begin
        flash_cnt_n = '0;
        flash_on_n  = 1'b1;
      end else if (flash_cnt_q == FW'(FLASH_HALF - 1)) begin
        flash_cnt_n = '0;
        flash_on_n  = !flash_on_q;
      end else begin
        flash_cnt_n = flash_cnt_q + 1'b1;
      end
    end
    if (phase_n == MAINT) begin
      red_n    = 1'b0;
      yellow_n = flash_on_n;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      phase_q       <= GREEN;
      ped_pending_q <= 1'b0;
      phase_done_q  <= 1'b0;
      ped_ack_q     <= 1'b0;
      green_q       <= 1'b1;
      yellow_q      <= 1'b0;
      red_q         <= 1'b0;
`ifdef LIGHT_SEQ_FLASH_YELLOW_EN
      flash_cnt_q   <= '0;
      flash_on_q    <= 1'b0;
`endif
    end else begin
      phase_q       <= phase_n;
      ped_pending_q <= ped_pending_n;
      phase_done_q  <= phase_done_n;
      ped_ack_q     <= ped_ack_n;
      green_q       <= green_n;
      yellow_q      <= yellow_n;
      red_q         <= red_n;
`ifdef LIGHT_SEQ_FLASH_YELLOW_EN
      flash_cnt_q   <= flash_cnt_n;
      flash_on_q    <= flash_on_n;
`endif
    end
  end

  assign bus.phase      = phase_q;
  assign bus.timer      = tmr_count;
  assign bus.phase_done = phase_done_q;
  assign bus.ped_ack    = ped_ack_q;
  assign bus.green      = green_q;
  assign bus.yellow     = yellow_q;
  assign bus.red        = red_q;

endmodule
